// File: rtl/dl_report_pkg.sv
// Shared types and helpers for the deadlock-report arbiter and its round-robin picker.
package dl_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_CLEAR,
    ST_CONFIRMED
  } state_e;

  localparam int unsigned RETRY_W    = 8;
  localparam int unsigned IDX_SCAN_W = 32;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [IDX_SCAN_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < int'(IDX_SCAN_W); i++) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_picker.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping at N.
module rr_onehot_picker
  import dl_report_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic [N-1:0] w_grant;
  logic         w_found;

  // Upper segment [ptr, N-1] has priority, then the wrapped segment [0, ptr-1].
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
        w_found    = 1'b1;
        w_grant[j] = 1'b1;
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!w_found && i_req[j]) begin
        w_found    = 1'b1;
        w_grant[j] = 1'b1;
      end
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = ID_W'(onehot_to_idx(IDX_SCAN_W'(w_grant)));
  assign o_any   = |i_req;

endmodule

// File: rtl/dl_report_arbiter.sv
// Deadlock-detection collector: picks a probe origin, waits for its token to return,
// then either latches a confirmed deadlock or clears the probe and retries elsewhere.
module dl_report_arbiter
  import dl_report_pkg::*;
#(
  parameter int unsigned PROC_NUM = 3,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned ID_W     = $clog2(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_confirmed,
  output logic [ID_W-1:0]     dl_proc_id,
  output logic [RETRY_W-1:0]  dl_retry_cnt
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               r_state, w_state_nxt;
  logic [PROC_NUM-1:0]  r_origin, w_origin_nxt;
  logic [ID_W-1:0]      r_origin_idx, w_origin_idx_nxt;
  logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
  logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
  logic                 r_detect, w_detect_nxt;
  logic                 r_token_clear, w_token_clear_nxt;
  logic                 r_confirmed, w_confirmed_nxt;
  logic [ID_W-1:0]      r_proc_id, w_proc_id_nxt;
  logic [RETRY_W-1:0]   r_retry, w_retry_nxt;

  logic [PROC_NUM-1:0]  w_grant;
  logic [ID_W-1:0]      w_grant_idx;
  logic                 w_any_req;

  rr_onehot_picker #(
    .N    (PROC_NUM),
    .ID_W (ID_W)
  ) u_picker (
    .i_req   (dl_in_vec),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any_req)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_origin      <= '0;
      r_origin_idx  <= '0;
      r_ptr         <= '0;
      r_timer       <= '0;
      r_detect      <= 1'b0;
      r_token_clear <= 1'b0;
      r_confirmed   <= 1'b0;
      r_proc_id     <= '0;
      r_retry       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_origin      <= w_origin_nxt;
      r_origin_idx  <= w_origin_idx_nxt;
      r_ptr         <= w_ptr_nxt;
      r_timer       <= w_timer_nxt;
      r_detect      <= w_detect_nxt;
      r_token_clear <= w_token_clear_nxt;
      r_confirmed   <= w_confirmed_nxt;
      r_proc_id     <= w_proc_id_nxt;
      r_retry       <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_origin_nxt      = r_origin;
    w_origin_idx_nxt  = r_origin_idx;
    w_ptr_nxt         = r_ptr;
    w_timer_nxt       = r_timer;
    w_detect_nxt      = r_detect;
    w_token_clear_nxt = 1'b0;
    w_confirmed_nxt   = r_confirmed;
    w_proc_id_nxt     = r_proc_id;
    w_retry_nxt       = r_retry;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_origin_nxt     = w_grant;
          w_origin_idx_nxt = w_grant_idx;
          w_detect_nxt     = 1'b1;
          w_state_nxt      = ST_ARM;
        end
      end
      // The origin's own flag is still up here, so it must not count as a return.
      ST_ARM: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if ((dl_in_vec & r_origin) != '0) begin
          w_confirmed_nxt = 1'b1;
          w_proc_id_nxt   = r_origin_idx;
          w_state_nxt     = ST_CONFIRMED;
        end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
          w_token_clear_nxt = 1'b1;
          w_origin_nxt      = '0;
          w_detect_nxt      = 1'b0;
          if (r_retry != '1) w_retry_nxt = r_retry + RETRY_W'(1);
          w_ptr_nxt = (r_origin_idx == ID_W'(PROC_NUM - 1)) ? '0 : r_origin_idx + ID_W'(1);
          w_state_nxt       = ST_CLEAR;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      ST_CLEAR:     w_state_nxt = ST_IDLE;
      ST_CONFIRMED: w_state_nxt = ST_CONFIRMED;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  assign dl_detect_out = r_detect;
  assign origin        = r_origin;
  assign token_clear   = r_token_clear;
  assign dl_confirmed  = r_confirmed;
  assign dl_proc_id    = r_proc_id;
  assign dl_retry_cnt  = r_retry;

endmodule

// File: doc/dl_report_arbiter.md
Name: dl_report_arbiter

Overview:
Simulation-side collector for the dataflow deadlock-detection network. It receives the per-process detection flags and picks one candidate process as the probe origin. It then drives the global detect/origin/token_clear signals back to every per-process detect unit, and either confirms a deadlock when the probe token returns or times out and clears the probe. Synthesizable; it sits at top level beside the per-process detect units in the generated deadlock detector.

Parameters:
PROC_NUM, 3, number of dataflow processes monitored; minimum 2.
TIMEOUT, 64, cycles in WAIT before the probe is abandoned; minimum 2.
ID_W, $clog2(PROC_NUM), width of process index.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-low reset.
dl_in_vec  in  PROC_NUM  per-process detect flag; bit i high = process i reports a blocked dependency, or a returned token when it is the origin.
dl_detect_out  out  1  high while a probe is in flight or confirmed; detect units freeze their dependency state while high.
origin  out  PROC_NUM  one-hot probe origin; all-zero when no probe is active.
token_clear  out  1  one-cycle pulse telling all units to discard tokens.
dl_confirmed  out  1  sticky deadlock-confirmed flag.
dl_proc_id  out  ID_W  index of the confirmed origin; valid while dl_confirmed is high.
dl_retry_cnt  out  8  saturating count of abandoned probes.

Behaviour:
- Reset: reset low at a rising edge sets the state to IDLE and drives all outputs to 0. The round-robin pointer resets to 0. Reset mid-probe or after confirmation aborts immediately with the same values. No token_clear pulse is issued on reset.
- States: IDLE, ARM, WAIT, CLEAR, CONFIRMED. All outputs are registered.
- IDLE: dl_detect_out=0, origin=0.
  - If dl_in_vec != 0, pick the first set bit at or after the pointer, wrapping at PROC_NUM. Register origin=onehot(pick) and dl_detect_out=1, then go to ARM.
  - If no bit is set, stay in IDLE.
- ARM: exactly 1 cycle. origin and dl_detect_out are held. dl_in_vec is ignored, so the candidate's own flag is not taken as a return. Clear the timer and go to WAIT.
- WAIT: the timer increments each cycle.
  - If (dl_in_vec & origin) != 0, go to CONFIRMED. This takes priority over timeout in the same cycle.
  - Else if timer == TIMEOUT-1, go to CLEAR.
  - Bits of dl_in_vec other than the origin bit are ignored.
- CLEAR: exactly 1 cycle.
  - token_clear=1, origin=0, dl_detect_out=0.
  - dl_retry_cnt increments, saturating at 255.
  - Pointer = (origin index + 1) mod PROC_NUM, so the next probe starts past the failed candidate.
  - Next state is IDLE. dl_in_vec is not sampled in CLEAR, so the earliest re-pick is seen 2 cycles after CLEAR.
- CONFIRMED: terminal until reset.
  - dl_confirmed=1, dl_proc_id=origin index.
  - dl_detect_out=1 and origin are held; token_clear=0; dl_in_vec is ignored.
- Latency:
  - dl_in_vec rising in IDLE → origin/dl_detect_out high at the next edge.
  - Earliest confirmation is at the 3rd edge after the pick: ARM, then a WAIT cycle sampling the return.
  - Timeout: CLEAR occurs ARM+TIMEOUT+1 cycles after the pick.
- Invariants:
  - origin is zero or one-hot.
  - token_clear never coincides with dl_detect_out=1.
  - dl_confirmed implies state CONFIRMED.

Decomposition:
- Package dl_report_pkg:
  - state enum (IDLE, ARM, WAIT, CLEAR, CONFIRMED);
  - RETRY_W=8;
  - function onehot_to_idx.
- One natural sub-module, rr_onehot_picker:
  - combinational rotate/priority/unrotate;
  - inputs req vector and pointer;
  - outputs one-hot grant, index and any_req.
- The arbiter instantiates the picker once.

Test Plan (PROC_NUM=3, TIMEOUT=8):
1. Reset hold, then dl_in_vec=000 for 20 cycles → state IDLE, all outputs 0, no token_clear.
2. dl_in_vec=010 at cycle 0, then origin bit reasserted at cycle 3 → origin=010 and dl_detect_out=1 from edge 1; dl_confirmed=1 and dl_proc_id=1 from edge 4; both hold through 50 cycles of arbitrary dl_in_vec.
3. dl_in_vec=011 held, origin bit kept low in WAIT → origin=001; token_clear pulses once at edge 10; retry_cnt=1. The next pick is origin=010 (pointer moved to 1), not 001.
4. In WAIT, origin bit returns on the same cycle the timer hits 7 → CONFIRMED, no token_clear.
5. Force 300 timeouts with dl_in_vec=100 and no return → dl_retry_cnt saturates at 255; origin is always 100.
6. Assert reset in WAIT and again in CONFIRMED → all outputs 0 at the next edge, pointer=0. The next pick with dl_in_vec=110 gives origin=010.
